pin_lock_controller: RTL and testbench

//  Parametrised successor to the 4-digit pincode checker: collects DIGITS one-hot key presses,

---
 rtl/pin_lock_if.sv | 24 ++
 rtl/pin_lock_controller.sv | 149 ++++++++++++++
 tb/tb_pin_lock_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pin_lock_if.sv
// rtl/pin_lock_if.sv - key/code inputs and lock status outputs of the pin lock controller
interface pin_lock_if #(
  parameter int DIGITS       = 4,
  parameter int MAX_ATTEMPTS = 3
);
  logic [3:0]                          key;
  logic [4*DIGITS-1:0]                 pinCode;
  logic                                unlock;
  logic                                lockout;
  logic                                error;
  logic [$clog2(MAX_ATTEMPTS+1)-1:0]   failCount;
  logic [4*DIGITS-1:0]                 pinEntry;
  logic [$clog2(DIGITS):0]             digitCounter;

  modport master (
    output key, pinCode,
    input  unlock, lockout, error, failCount, pinEntry, digitCounter
  );

  modport slave (
    input  key, pinCode,
    output unlock, lockout, error, failCount, pinEntry, digitCounter
  );
endinterface

// File: rtl/pin_lock_controller.sv
// rtl/pin_lock_controller.sv - pin entry, compare, timed unlock and lockout; PINLOCK_DEBUG_EN exposes entry
module pin_lock_controller #(
  parameter int DIGITS         = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int UNLOCK_CYCLES  = 20,
  parameter int LOCKOUT_CYCLES = 50,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  pin_lock_if.slave  bus
);
  localparam int NW   = 4 * DIGITS;
  localparam int FW   = $clog2(MAX_ATTEMPTS + 1);
  localparam int CW   = $clog2(DIGITS) + 1;
  localparam int TM1  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX = (TM1 > TIMEOUT_CYCLES) ? TM1 : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t          r_state;
  logic [3:0]      r_key_prev;
  logic [NW-1:0]   r_pin_entry;
  logic [CW-1:0]   r_digit_cnt;
  logic [FW-1:0]   r_fail_count;
  logic [TW-1:0]   r_timer;
  logic            r_unlock;
  logic            r_lockout;
  logic            r_error;

  logic            w_press;
  logic            w_last_digit;
  logic [NW-1:0]   w_shifted;

  // A press is a rising transition out of the all-released key state.
  assign w_press      = (bus.key != 4'd0) && (r_key_prev == 4'd0);
  assign w_last_digit = (r_digit_cnt == CW'(DIGITS - 1));

  generate
    if (DIGITS == 1) begin : g_one_digit
      assign w_shifted = bus.key;
    end else begin : g_multi_digit
      assign w_shifted = {r_pin_entry[NW-5:0], bus.key};
    end
  endgenerate

  // Main controller: entry collection, check, timed unlock and lockout, all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_key_prev   <= 4'hF;
      r_pin_entry  <= '0;
      r_digit_cnt  <= '0;
      r_fail_count <= '0;
      r_timer      <= '0;
      r_unlock     <= 1'b0;
      r_lockout    <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_key_prev <= bus.key;
      r_error    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_pin_entry <= w_shifted;
            r_digit_cnt <= r_digit_cnt + 1'b1;
            r_timer     <= '0;
            r_state     <= w_last_digit ? S_CHECK : S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (w_press) begin
            r_pin_entry <= w_shifted;
            r_digit_cnt <= r_digit_cnt + 1'b1;
            r_timer     <= '0;
            if (w_last_digit) r_state <= S_CHECK;
          end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            // Abandoned partial entry: discard silently, attempts are not charged.
            r_pin_entry <= '0;
            r_digit_cnt <= '0;
            r_timer     <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_CHECK: begin
          r_pin_entry <= '0;
          r_digit_cnt <= '0;
          r_timer     <= '0;
          if (r_pin_entry == bus.pinCode) begin
            r_unlock     <= 1'b1;
            r_fail_count <= '0;
            r_state      <= S_UNLOCKED;
          end else if (int'(r_fail_count) + 1 < MAX_ATTEMPTS) begin
            r_fail_count <= r_fail_count + 1'b1;
            r_error      <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_lockout    <= 1'b1;
            r_fail_count <= FW'(MAX_ATTEMPTS);
            r_state      <= S_LOCKOUT;
          end
        end
        S_UNLOCKED: begin
          if (r_timer == TW'(UNLOCK_CYCLES - 1)) begin
            r_unlock <= 1'b0;
            r_timer  <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (r_timer == TW'(LOCKOUT_CYCLES - 1)) begin
            r_lockout    <= 1'b0;
            r_fail_count <= '0;
            r_timer      <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.unlock    = r_unlock;
  assign bus.lockout   = r_lockout;
  assign bus.error     = r_error;
  assign bus.failCount = r_fail_count;

`ifdef PINLOCK_DEBUG_EN
  assign bus.pinEntry     = r_pin_entry;
  assign bus.digitCounter = r_digit_cnt;
`else
  assign bus.pinEntry     = '0;
  assign bus.digitCounter = '0;
`endif

endmodule

// File: tb/tb_pin_lock_controller.sv
// tb/tb_pin_lock_controller.sv - directed and randomized checks of pin_lock_controller against a reference model
module tb_pin_lock_controller;
  localparam int DIGITS         = 4;
  localparam int MAX_ATTEMPTS   = 3;
  localparam int UNLOCK_CYCLES  = 20;
  localparam int LOCKOUT_CYCLES = 50;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int NW             = 4 * DIGITS;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pin_lock_if #(.DIGITS(DIGITS), .MAX_ATTEMPTS(MAX_ATTEMPTS)) bus ();

  pin_lock_controller #(
    .DIGITS(DIGITS), .MAX_ATTEMPTS(MAX_ATTEMPTS), .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the digits typed so far, and countdowns for the timed phases.
  logic [3:0] m_digits[$];
  logic [3:0] m_prev;
  int         m_idle;
  int         m_unlock_left;
  int         m_lock_left;
  int         m_fails;
  bit         m_check_due;
  bit         m_error;

  function automatic logic [NW-1:0] entry_value();
    logic [NW-1:0] v;
    v = '0;
    foreach (m_digits[i]) v = (v << 4) | NW'(m_digits[i]);
    return v;
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] k, input logic [NW-1:0] code);
    bit press;
    if (rst) begin
      m_digits.delete();
      m_prev = 4'hF; m_idle = 0; m_unlock_left = 0; m_lock_left = 0;
      m_fails = 0; m_check_due = 0; m_error = 0;
      return;
    end
    press  = (k != 4'd0) && (m_prev == 4'd0);
    m_prev = k;
    m_error = 0;
    if (m_check_due) begin
      m_check_due = 0;
      if (entry_value() == code) begin
        m_unlock_left = UNLOCK_CYCLES;
        m_fails = 0;
      end else if (m_fails + 1 < MAX_ATTEMPTS) begin
        m_fails++;
        m_error = 1;
      end else begin
        m_lock_left = LOCKOUT_CYCLES;
        m_fails = MAX_ATTEMPTS;
      end
      m_digits.delete();
    end else if (m_unlock_left > 0) begin
      m_unlock_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (press) begin
      m_digits.push_back(k);
      m_idle = 0;
      if (m_digits.size() == DIGITS) m_check_due = 1;
    end else if (m_digits.size() > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT_CYCLES) begin
        m_digits.delete();
        m_idle = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(reset, bus.key, bus.pinCode);
    #1;
    check("unlock",    32'(bus.unlock),    32'(m_unlock_left > 0));
    check("lockout",   32'(bus.lockout),   32'(m_lock_left > 0));
    check("error",     32'(bus.error),     32'(m_error));
    check("failCount", 32'(bus.failCount), 32'(m_fails));
`ifdef PINLOCK_DEBUG_EN
    check("pinEntry",     32'(bus.pinEntry),     32'(entry_value()));
    check("digitCounter", 32'(bus.digitCounter), 32'(m_digits.size()));
`else
    check("pinEntry",     32'(bus.pinEntry),     32'd0);
    check("digitCounter", 32'(bus.digitCounter), 32'd0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int gap);
    bus.key = d;
    idle(hold);
    bus.key = 4'd0;
    idle(gap);
  endtask

  task automatic enter(input logic [NW-1:0] code, input int hold, input int gap);
    logic [NW-1:0] c;
    c = code;
    for (int i = DIGITS - 1; i >= 0; i--) press(c[4*i +: 4], hold, gap);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] rand_onehot();
    return 4'b0001 << $urandom_range(0, 3);
  endfunction

  function automatic logic [NW-1:0] rand_code();
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v = (v << 4) | NW'(rand_onehot());
    return v;
  endfunction

  initial begin
    reset       = 1'b1;
    bus.key     = 4'd0;
    bus.pinCode = 16'h8481;
    m_prev      = 4'hF;
    do_reset(2);
    idle(2);

    enter(16'h8481, 1, 1);
    idle(25);

    enter(16'h1248, 1, 1);
    idle(3);

    do_reset(1);
    enter(16'h1111, 1, 1);
    idle(2);
    enter(16'h2222, 1, 1);
    idle(2);
    enter(16'h4444, 1, 1);
    press(4'h8, 1, 3);
    press(4'h4, 2, 3);
    idle(50);
    enter(16'h8481, 1, 1);
    idle(24);

    press(4'h8, 1, 1);
    press(4'h4, 1, 1);
    idle(18);
    enter(16'h8481, 1, 1);
    idle(24);

    press(4'h8, 10, 1);
    press(4'h4, 1, 1);
    press(4'h8, 1, 1);
    press(4'h1, 1, 1);
    idle(24);

    press(4'h8, 1, 1);
    press(4'h4, 1, 1);
    press(4'h8, 1, 1);
    bus.key = 4'h8;
    do_reset(1);
    idle(3);
    bus.key = 4'h0;
    idle(2);
    enter(16'h8481, 1, 1);
    idle(24);

    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: enter(bus.pinCode, $urandom_range(1, 3), $urandom_range(0, 2));
        4, 5, 6:    enter(rand_code(), $urandom_range(1, 2), $urandom_range(1, 2));
        7: begin
          for (int j = 0; j < int'($urandom_range(1, DIGITS - 1)); j++) press(rand_onehot(), 1, 1);
          idle($urandom_range(5, 25));
        end
        8: press(4'($urandom_range(1, 15)), $urandom_range(1, 3), $urandom_range(1, 4));
        default: begin
          if ($urandom_range(0, 1) == 0) bus.pinCode = rand_code();
          else do_reset($urandom_range(1, 2));
        end
      endcase
      idle($urandom_range(0, 4));
    end
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
